// File: rtl/sort_feeder_pkg.sv
// Shared constants for the sorter feeder: batch size, sorter latency and fill-count encoding.
// out_data packing: element i occupies bits [i*W +: W], so s0 (smallest) sits at the LSBs.
package sort_feeder_pkg;
  localparam int SORT_N       = 4;
  localparam int SORT_LATENCY = 3;
  localparam int CNT_BITS     = $clog2(SORT_N + 1);
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(SORT_N);
endpackage

// File: rtl/feeder_stage_buf.sv
// Four-slot staging buffer: accepts serial elements in arrival order and reports when full.
module feeder_stage_buf
  import sort_feeder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         launch,
  output logic         full_next,
  output logic [W-1:0] x0,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic [W-1:0] x3
);
  logic [CNT_BITS-1:0] count_r;
  logic [CNT_BITS-1:0] count_nxt_s;
  logic [W-1:0]        slot_r [SORT_N];
  logic                accept_s;

  // Handshake and next fill count; launch empties the buffer logically (slots keep data).
  always_comb begin
    in_ready = (count_r < FULL_CNT);
    accept_s = in_valid && in_ready;
    if (launch) begin
      count_nxt_s = '0;
    end else if (accept_s) begin
      count_nxt_s = count_r + CNT_BITS'(1);
    end else begin
      count_nxt_s = count_r;
    end
    full_next = (count_nxt_s == FULL_CNT);
  end

  // Fill count and slot storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
      for (int i = 0; i < SORT_N; i++) slot_r[i] <= '0;
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < SORT_N; i++) begin
        if (accept_s && (count_r == CNT_BITS'(i))) slot_r[i] <= in_data;
      end
    end
  end

  assign x0 = slot_r[0];
  assign x1 = slot_r[1];
  assign x2 = slot_r[2];
  assign x3 = slot_r[3];
endmodule

// File: rtl/sort_feeder.sv
// Feeder around a 4-entry sorter: stages a batch, pulses the sorter's reset to launch it,
// captures the sorted result on done and offers it on a valid/ready output.
module sort_feeder
  import sort_feeder_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_data,
  output logic [W-1:0]      sort_x0,
  output logic [W-1:0]      sort_x1,
  output logic [W-1:0]      sort_x2,
  output logic [W-1:0]      sort_x3,
  output logic              sort_start,
  input  logic [W-1:0]      sort_s0,
  input  logic [W-1:0]      sort_s1,
  input  logic [W-1:0]      sort_s2,
  input  logic [W-1:0]      sort_s3,
  input  logic              sort_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SORT_N*W-1:0] out_data,
  output logic [CNT_W-1:0]  batch_count
);
  logic                busy_r;
  logic                busy_nxt_s;
  logic                sort_start_r;
  logic                start_nxt_s;
  logic                full_next_s;
  logic                capture_s;
  logic                deliver_s;
  logic                out_valid_r;
  logic [SORT_N*W-1:0] out_data_r;
  logic [CNT_W-1:0]    batch_count_r;

  feeder_stage_buf #(.W(W)) u_stage (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .launch    (sort_start_r),
    .full_next (full_next_s),
    .x0        (sort_x0),
    .x1        (sort_x1),
    .x2        (sort_x2),
    .x3        (sort_x3)
  );

  // start is registered one cycle early so it is high exactly while count==4 && !busy.
  always_comb begin
    capture_s = busy_r && sort_done && (!out_valid_r || out_ready);
    deliver_s = out_valid_r && out_ready;
    if (sort_start_r) begin
      busy_nxt_s = 1'b1;
    end else if (capture_s) begin
      busy_nxt_s = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    start_nxt_s = full_next_s && !busy_nxt_s;
  end

  // Launch/busy tracking, result register and delivered-batch counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r        <= 1'b0;
      sort_start_r  <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
      batch_count_r <= '0;
    end else begin
      busy_r       <= busy_nxt_s;
      sort_start_r <= start_nxt_s;
      if (capture_s) begin
        out_data_r  <= {sort_s3, sort_s2, sort_s1, sort_s0};
        out_valid_r <= 1'b1;
      end else if (deliver_s) begin
        out_valid_r <= 1'b0;
      end
      if (deliver_s) batch_count_r <= batch_count_r + CNT_W'(1);
    end
  end

  assign sort_start  = sort_start_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign batch_count = batch_count_r;
endmodule

// File: doc/sort_feeder.md
Name: sort_feeder

Overview:
- Upstream/downstream companion for the 4-entry nibble sorter (Sorter4).
- Collects four W-bit values from a serial valid/ready stream into a staging buffer, then launches the sorter with a one-cycle start pulse driven onto the sorter's synchronous reset.
- Waits for the sorter's done, captures the four sorted values into a result register, and presents them on a valid/ready output.
- The staging buffer refills while a sort is in flight, so batches overlap.

Parameters:
- W, 4, element width; must equal the sorter data width.
- CNT_W, 8, width of the completed-batch counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  feeder can accept an element.
- in_data  in  W  upstream element.
- sort_x0..sort_x3  out  W each  staged batch; connect to sorter x0..x3.
- sort_start  out  1  one-cycle launch pulse; connect to sorter reset.
- sort_s0..sort_s3  in  W each  sorter outputs s0..s3.
- sort_done  in  1  sorter done.
- out_valid  out  1  sorted batch available.
- out_ready  in  1  downstream accepts the batch.
- out_data  out  4*W  {s3,s2,s1,s0}; s0 is in bits [W-1:0], smallest value.
- batch_count  out  CNT_W  number of batches delivered; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset_n low, async):
  - fill count = 0; staging registers = 0; busy = 0.
  - out_valid = 0; out_data = 0; batch_count = 0; sort_start = 0.
  - in_ready = 1 after reset release.
- Fill:
  - in_ready = (count < 4).
  - On in_valid && in_ready: store in_data into slot[count] (first element goes to sort_x0), then count++.
  - sort_x0..3 are driven directly from the slot registers.
- Launch:
  - Condition: count == 4 && !busy.
  - sort_start = 1 for exactly that cycle (registered, glitch-free).
  - At that clock edge: count <- 0 and busy <- 1. The sorter samples x0..x3 on the same edge.
  - Slots keep their old values until overwritten.
  - Refill may start the following cycle.
- Wait:
  - sort_done is ignored whenever busy == 0. This covers stale done from a previous batch or an unreset sorter.
  - After launch, the sorter asserts done 3 cycles later: launch edge + 3 edges.
- Capture:
  - Condition: busy && sort_done && (!out_valid || out_ready).
  - At that edge: out_data <- sorted values, out_valid <- 1, busy <- 0.
  - If the result register is occupied and not being accepted, capture stalls. The sorter holds its result in its done state, so nothing is lost.
- Output:
  - out_valid && out_ready → batch_count++ at that edge.
  - out_valid clears unless a capture happens on the same edge; a simultaneous capture refills the register back-to-back.
  - out_data is stable while out_valid && !out_ready.
- Simultaneous events:
  - A launch and a capture cannot coincide, because launch requires !busy.
  - A fill handshake cannot coincide with a launch, because count == 4 forces in_ready = 0.
- Minimum latency: last input accepted at edge T → launch cycle T+1 → capture edge T+5 → out_valid high in cycle T+5.
- Throughput: one batch per 5 cycles when fill keeps pace.
- Reset mid-operation:
  - Everything in the feeder clears and the in-flight batch is discarded.
  - The sorter is not reset by reset_n; its done is ignored until the next launch reinitialises it.
- Width rule: compare and sort semantics belong to the sorter; the feeder never modifies data.

Decomposition:
- Shared package: localparams for SORT_N = 4 and SORT_LATENCY = 3, plus the packing order of out_data. The testbench uses the same package.
- One sub-module is natural: feeder_stage_buf (4-slot fill buffer with count and in_ready).
- Launch, busy and capture logic plus the result register stay in the top module.
- The sorter is instantiated beside the feeder at the next level up, not inside it.

Test Plan:
- Reset, then feed 9,3,7,1 with out_ready=1 → sort_start pulses once; out_data = {9,7,3,1} i.e. 0x9731; out_valid 5 cycles after the 4th accept; batch_count = 1.
- Feed 2,2,0,15 then 15,14,13,12 back-to-back, out_ready=1 → second batch fills during the first sort; results 0xF220 then 0xFEDC; batch_count = 2.
- Hold out_ready=0 across two batches → first result held stable; third launch blocked (in_ready=0 once 4 staged); release out_ready → results delivered in order, nothing lost.
- Tie sort_done=1 before any launch → out_valid stays 0 and busy stays 0.
- Assert reset_n low mid-fill (2 elements) and mid-sort → all outputs at reset values; the next full batch 4,1,3,2 yields 0x4321.
- Run 256 batches with CNT_W=8 → batch_count wraps to 0.
